sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
// Upstream feeder for the single-block SHA-256 core. Accepts a message as a
// stream of big-endian 32-bit words and builds the padded 16-word block
// (0x80 marker, zero fill, 64-bit bit-length). Drives the core's block, seed
// and start inputs, then captures the 8-word digest when the core finishes.
// Only messages of at most 55 bytes are accepted (one block).
// PARAMETERS
// MAX_BYTES  55  largest accepted message in bytes; fixed by the single-block limit
// PORTS
// clk             in   1      clock
// reset_n         in   1      asynchronous active-low reset
// in_valid        in   1      in_data word valid
// in_ready        out  1      padder accepts word (transfer = in_valid & in_ready)
// in_data         in   32     message word, first byte in [31:24]
// in_last         in   1      final word of message
// in_bytes_last   in   3      valid bytes in final word, 1..4 (0 only as sole word = empty msg)
// msg_block       out  32x16  padded block, to core mem_read_data
// hash_seed       out  32x8   initial H0..H7, to core hash
// core_start      out  1      one-cycle start pulse to core
// core_done       in   1      core idle flag (high in core IDLE)
// core_digest     in   32x8   core result words (core mem_write_data)
// digest          out  32x8   captured digest
// digest_valid    out  1      one-cycle pulse, digest updated
// err_len         out  1      one-cycle pulse, message rejected (too long)
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, core_start=0, digest_valid=0, err_len=0,
//   msg_block/digest all zero, counters zero. hash_seed is constant SHA256_H0.
// - States: IDLE -> LOAD -> PAD -> START -> WAIT_LO -> WAIT_HI -> CAPTURE -> IDLE.
// - IDLE/LOAD: in_ready=1. Each transfer writes msg_block[wcnt] and bumps
//   wcnt (4b) and byte count L (6b, +4 or +in_bytes_last on last). IDLE moves
//   to LOAD on the first transfer, or straight to PAD if in_last.
// - Overflow: a transfer with wcnt>=14, or a final L>MAX_BYTES, sets ovf. Data
//   is discarded and counters saturate. Input drains until in_last. Then err_len
//   pulses for 1 cycle and the state returns to IDLE. No core_start is issued.
// - PAD (1 cycle, in_ready=0): byte L of the block = 0x80, bytes L+1..55 = 0,
//   word14 = 0, word15 = {23'b0, L, 3'b0}. Bytes past in_bytes_last are
//   overwritten regardless of input content.
// - START: core_start=1 for exactly one cycle. The block is stable from PAD
//   until CAPTURE exits and must not change while the core runs.
// - WAIT_LO waits for core_done=0. WAIT_HI waits for core_done=1 (core result
//   is registered before its done rises).
// - CAPTURE: digest <= core_digest, digest_valid=1 for one cycle. IDLE follows.
// - Latency: last accepted word at cycle T -> PAD T+1 -> core_start T+2.
// - in_ready=0 in all states except IDLE/LOAD. There is no back-to-back overlap
//   with the core.
// - in_bytes_last is sampled only with in_last. Values 5..7 are treated as 4.
//   A value of 0 on a non-sole last word is treated as 4.
// - Reset mid-operation aborts immediately with no pulses. The core is reset
//   by the same reset_n.
// - Lengths use the 6-bit L. Bit-length fits 9 bits (max 440).
// STRUCTURE
// - sha256_pkg: SHA256_H0[8] constants, MAX_BLOCK_BYTES=55, state enum
//   typedef, word/block array typedefs. Shared with the core.
// - One combinational sub-module, sha256_pad_word, gives one padded word from
//   (raw word, word index, L). It is instantiated 16x in PAD.
// - The FSM, counters and capture stay in this module.
// TESTING
// - "abc": one word 0x61626300, last, bytes=3 -> block[0]=0x61626380,
//   [1..14]=0, [15]=0x18. digest[0]=0xba7816bf, digest[7]=0xf20015ad.
// - Empty: one word, last, bytes=0 -> block[0]=0x80000000, [15]=0.
//   digest[0]=0xe3b0c442.
// - 55 bytes (14 words, last bytes=3) -> marker at block[13][7:0]=0x80,
//   [15]=0x1b8. core_start 2 cycles after the last transfer.
// - 56 bytes (14 words, last bytes=4) -> err_len pulse, no core_start,
//   in_ready=1 next cycle.
// - 20 words without in_last, then last -> all accepted, one err_len after the
//   last word, block not issued.
// - in_valid toggled randomly mid-message; reset_n pulsed while in WAIT_HI ->
//   no digest_valid, all outputs at reset values.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the padder and the single-block core.
package sha256_pkg;

    localparam int MAX_BLOCK_BYTES = 55;

    typedef logic [31:0]        word_t;
    typedef logic [15:0][31:0]  block_t;
    typedef logic [7:0][31:0]   digest_t;

    // Element [0] is H0.
    localparam digest_t SHA256_H0 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        START,
        WAIT_LO,
        WAIT_HI,
        CAPTURE
    } state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Produces one word of the padded block from the raw word, its index and the
// message length: message bytes kept, 0x80 marker at byte L, zeros after, length in word 15.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  word_t       raw_word,
    input  logic [3:0]  word_idx,
    input  logic [5:0]  msg_len,
    output word_t       padded_word
);

    logic [7:0] byte_out [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        logic [5:0] pos;
        assign pos = {word_idx, 2'b00} + 6'(gi);
        assign byte_out[gi] = (pos < msg_len)  ? raw_word[31-8*gi -: 8] :
                              (pos == msg_len) ? 8'h80 : 8'h00;
    end

    always_comb begin
        padded_word = '0;
        if (word_idx == 4'd15) begin
            padded_word = {23'b0, msg_len, 3'b000};
        end else if (word_idx != 4'd14) begin
            padded_word = {byte_out[0], byte_out[1], byte_out[2], byte_out[3]};
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Collects a short message as 32-bit words, pads it into one SHA-256 block,
// starts the core and captures its digest; over-long messages are drained and flagged.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BLOCK_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes_last,
    output block_t      msg_block,
    output digest_t     hash_seed,
    output logic        core_start,
    input  logic        core_done,
    input  digest_t     core_digest,
    output digest_t     digest,
    output logic        digest_valid,
    output logic        err_len
);

    state_t     state_reg, state_next;
    logic [3:0] wcnt_reg;
    logic [5:0] len_reg;
    logic       ovf_reg;
    logic       err_reg;
    block_t     block_reg;
    digest_t    digest_reg;
    word_t      padded_words [16];

    logic       accepting;
    logic       xfer;
    logic [2:0] last_bytes;
    logic [6:0] len_sum;
    logic       ovf_now;

    assign accepting = (state_reg == IDLE) || (state_reg == LOAD);
    assign xfer      = in_valid && accepting;

    // Byte count and overflow decision for the word on the bus this cycle.
    always_comb begin
        last_bytes = in_bytes_last;
        if (in_bytes_last > 3'd4 || (in_bytes_last == 3'd0 && wcnt_reg != 4'd0)) begin
            last_bytes = 3'd4;
        end
        len_sum = {1'b0, len_reg} + (in_last ? {4'b0, last_bytes} : 7'd4);
        ovf_now = ovf_reg || (wcnt_reg >= 4'd14) || (in_last && len_sum > 7'(MAX_BYTES));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (in_last) state_next = ovf_now ? IDLE : PAD;
                    else         state_next = LOAD;
                end
            end
            PAD:     state_next = START;
            START:   state_next = WAIT_LO;
            WAIT_LO: if (!core_done) state_next = WAIT_HI;
            WAIT_HI: if (core_done)  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_pad
        sha256_pad_word u_pad_word (
            .raw_word    (block_reg[gi]),
            .word_idx    (4'(gi)),
            .msg_len     (len_reg),
            .padded_word (padded_words[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            wcnt_reg   <= '0;
            len_reg    <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
            block_reg  <= '0;
            digest_reg <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= xfer && in_last && ovf_now;
            if (xfer) begin
                if (in_last && ovf_now) begin
                    wcnt_reg <= '0;
                    len_reg  <= '0;
                    ovf_reg  <= 1'b0;
                end else if (ovf_now) begin
                    ovf_reg <= 1'b1;
                end else begin
                    block_reg[wcnt_reg] <= in_data;
                    wcnt_reg            <= wcnt_reg + 4'd1;
                    len_reg             <= len_sum[5:0];
                end
            end
            if (state_reg == PAD) begin
                for (int i = 0; i < 16; i++) block_reg[i] <= padded_words[i];
            end
            // The core registers its result no later than the rise of done.
            if (state_reg == WAIT_HI && core_done) begin
                digest_reg <= core_digest;
            end
            if (state_reg == CAPTURE) begin
                wcnt_reg <= '0;
                len_reg  <= '0;
                ovf_reg  <= 1'b0;
            end
        end
    end

    assign in_ready     = accepting;
    assign msg_block    = block_reg;
    assign hash_seed    = SHA256_H0;
    assign core_start   = (state_reg == START);
    assign digest       = digest_reg;
    assign digest_valid = (state_reg == CAPTURE);
    assign err_len      = err_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder with a behavioural single-block SHA-256 core and byte-level padding model.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_bytes_last = '0;
    block_t      msg_block;
    digest_t     hash_seed;
    logic        core_start;
    logic        core_done;
    digest_t     core_digest;
    digest_t     digest;
    logic        digest_valid;
    logic        err_len;

    int vectors = 0;
    int miscompares = 0;
    int core_cnt;

    localparam digest_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_padder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_bytes_last (in_bytes_last),
        .msg_block     (msg_block),
        .hash_seed     (hash_seed),
        .core_start    (core_start),
        .core_done     (core_done),
        .core_digest   (core_digest),
        .digest        (digest),
        .digest_valid  (digest_valid),
        .err_len       (err_len)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic digest_t sha256_compress(input block_t blk, input digest_t iv);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        digest_t res;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3];
        e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        res[0] = iv[0] + a; res[1] = iv[1] + b; res[2] = iv[2] + c; res[3] = iv[3] + d;
        res[4] = iv[4] + e; res[5] = iv[5] + f; res[6] = iv[6] + g; res[7] = iv[7] + h;
        return res;
    endfunction

    // Behavioural core: goes busy on start, raises done with the digest some cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_done   <= 1'b1;
            core_cnt    <= 0;
            core_digest <= '0;
        end else if (core_start && core_done) begin
            core_done <= 1'b0;
            core_cnt  <= 4 + int'($urandom_range(0, 6));
        end else if (!core_done) begin
            if (core_cnt <= 1) begin
                core_digest <= sha256_compress(msg_block, hash_seed);
                core_done   <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_digest_valid"}, digest_valid, 0);
        chk({tag, "_err_len"}, err_len, 0);
        chk({tag, "_msg_block"}, msg_block, 0);
        chk({tag, "_digest"}, digest, 0);
        chk({tag, "_hash_seed"}, hash_seed, IV);
    endtask

    task automatic run_msg(input logic [7:0] msg [$], input bit abort_hi);
        int n, nw, lbytes, cyc;
        logic [7:0] pb [64];
        block_t ref_blk;
        logic [31:0] word;
        logic [2:0] enc;
        bit ok, seen;
        n = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        lbytes = n - 4 * (nw - 1);
        ok = (n <= 55);
        for (int i = 0; i < 64; i++) pb[i] = 8'h00;
        if (ok) begin
            for (int i = 0; i < n; i++) pb[i] = msg[i];
            pb[n]  = 8'h80;
            pb[62] = 8'((n * 8) >> 8);
            pb[63] = 8'(n * 8);
        end
        for (int w = 0; w < 16; w++) ref_blk[w] = {pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]};

        for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            word = $urandom;
            for (int k = 0; k < 4; k++) if (4 * w + k < n) word[31-8*k -: 8] = msg[4*w+k];
            enc = 3'(lbytes);
            if (lbytes == 4) enc = (nw > 1 && $urandom_range(0, 3) == 0) ? 3'd0 : 3'(4 + $urandom_range(0, 3));
            in_valid      = 1'b1;
            in_data       = word;
            in_last       = (w == nw - 1);
            in_bytes_last = (w == nw - 1) ? enc : 3'($urandom);
            chk("in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = $urandom;
        end

        if (ok) begin
            chk("pad_no_start", core_start, 0);
            chk("pad_ready_low", in_ready, 0);
            @(posedge clk); #1;
            chk("start_latency", core_start, 1);
            chk("block", msg_block, ref_blk);
            if (abort_hi) begin
                repeat (2) begin @(posedge clk); #1; end
                reset_n = 1'b0;
                #1;
                chk_reset_state("abort");
                @(posedge clk); #1;
                reset_n = 1'b1;
                seen = 1'b0;
                repeat (30) begin
                    @(posedge clk); #1;
                    if (digest_valid || core_start) seen = 1'b1;
                end
                chk("abort_quiet", seen, 0);
            end else begin
                @(posedge clk); #1;
                chk("start_one_cycle", core_start, 0);
                cyc = 0;
                while (!digest_valid && cyc < 300) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                chk("digest_valid_seen", digest_valid, 1);
                chk("digest", digest, sha256_compress(ref_blk, IV));
                chk("block_stable", msg_block, ref_blk);
                @(posedge clk); #1;
                chk("digest_valid_pulse", digest_valid, 0);
                chk("ready_after", in_ready, 1);
            end
        end else begin
            chk("err_len", err_len, 1);
            chk("err_ready", in_ready, 1);
            chk("err_no_start", core_start, 0);
            seen = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
                if (core_start || err_len) seen = 1'b1;
            end
            chk("err_quiet", seen, 0);
        end
    endtask

    initial begin
        logic [7:0] m [$];
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("post_reset");

        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        chk("abc_block0", msg_block[0], 32'h61626380);
        chk("abc_block15", msg_block[15], 32'h18);
        chk("abc_digest0", digest[0], 32'hba7816bf);
        chk("abc_digest7", digest[7], 32'hf20015ad);

        m = {};
        run_msg(m, 1'b0);
        chk("empty_block0", msg_block[0], 32'h80000000);
        chk("empty_block15", msg_block[15], 32'h0);
        chk("empty_digest0", digest[0], 32'he3b0c442);

        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);
        chk("b55_marker", msg_block[13][7:0], 8'h80);
        chk("b55_len", msg_block[15], 32'h1b8);

        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);

        m = {};
        for (int i = 0; i < 84; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);

        for (int t = 0; t < 14; t++) begin
            n = (t % 4 == 3) ? int'($urandom_range(56, 64)) : int'($urandom_range(0, 55));
            m = {};
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            run_msg(m, 1'b0);
        end

        m = {};
        for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b1);

        m = {};
        for (int i = 0; i < 23; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
